// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send, then shifts
// a command byte (LSB first, odd parity, stop) on device clock falls and checks the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 150000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t           state_q;
  logic             clk_meta_q, clk_sync_q, clk_prev_q;
  logic             data_meta_q, data_sync_q;
  logic [7:0]       data_q;
  logic             parity_q;
  logic [3:0]       bit_idx_q;
  logic [INH_W-1:0] inh_cnt_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             clk_oe_q, data_oe_q, busy_q, done_q, error_q;

  logic fall;
  logic to_hit;
  logic bit_d;

  assign fall   = clk_prev_q & ~clk_sync_q;
  assign to_hit = (to_cnt_q == TO_LAST);

  // Bit for the current frame slot: data 1..7, then parity, then stop (always 1).
  always_comb begin
    bit_d = 1'b1;
    if (bit_idx_q < 4'd8) begin
      bit_d = data_q[bit_idx_q[2:0]];
    end else if (bit_idx_q == 4'd8) begin
      bit_d = parity_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      data_q      <= 8'h00;
      parity_q    <= 1'b0;
      bit_idx_q   <= 4'd0;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      clk_meta_q  <= ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
      done_q      <= 1'b0;
      error_q     <= 1'b0;

      case (state_q)
        IDLE: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          if (tx_start) begin
            data_q    <= tx_data;
            parity_q  <= ~^tx_data;
            bit_idx_q <= 4'd0;
            inh_cnt_q <= '0;
            clk_oe_q  <= 1'b1;
            data_oe_q <= (INHIBIT_CYCLES == 1);
            busy_q    <= 1'b1;
            state_q   <= INHIBIT;
          end
        end

        // Start bit goes low during the final inhibit cycle, while the clock is still held.
        INHIBIT: begin
          if (inh_cnt_q == INH_LAST) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b1;
            to_cnt_q  <= '0;
            state_q   <= REQ;
          end else begin
            inh_cnt_q <= inh_cnt_q + INH_W'(1);
            if (inh_cnt_q == INH_PRE) begin
              data_oe_q <= 1'b1;
            end
          end
        end

        REQ, SHIFT, ACK, WAIT_IDLE: begin
          if (to_hit) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            error_q   <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
            case (state_q)
              REQ: begin
                if (fall) begin
                  data_oe_q <= ~data_q[0];
                  bit_idx_q <= 4'd1;
                  state_q   <= SHIFT;
                end
              end
              SHIFT: begin
                if (fall) begin
                  data_oe_q <= ~bit_d;
                  bit_idx_q <= bit_idx_q + 4'd1;
                  if (bit_idx_q == 4'd9) begin
                    state_q <= ACK;
                  end
                end
              end
              ACK: begin
                if (fall) begin
                  if (data_sync_q) begin
                    error_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                  end else begin
                    state_q <= WAIT_IDLE;
                  end
                end
              end
              default: begin
                if (clk_sync_q && data_sync_q) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
                end
              end
            endcase
          end
        end

        default: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model clocks frames out of the host,
// and observed bits, pulses and line timing are compared with values derived from the byte.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TO  = 500;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       dev_clk, dev_data;
  logic       ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
  logic       clk_line, data_line;

  assign clk_line  = dev_clk & ~ps2_clk_oe;
  assign data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .ps2_clk_in (clk_line),
    .ps2_data_in(data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Line monitors, sampled on the falling clock edge.
  int   cnt_done = 0, cnt_err = 0, cnt_clkoe = 0, cnt_both = 0;
  int   viol = 0, oe_after_err = 0, busy_bad = 0;
  logic s1 = 1'b1, s2 = 1'b1;
  logic prev_oe = 1'b0, prev_err = 1'b0, prev_busy = 1'b0;
  bit   mon_en = 1'b0;

  always @(posedge clock) begin
    s1 <= clk_line;
    s2 <= s1;
  end

  always @(negedge clock) begin
    if (tx_done === 1'b1) cnt_done++;
    if (tx_error === 1'b1) cnt_err++;
    if (ps2_clk_oe === 1'b1) cnt_clkoe++;
    if (tx_done === 1'b1 && tx_error === 1'b1) cnt_both++;
    if ((prev_err || tx_error === 1'b1) && (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0)) oe_after_err++;
    if (mon_en && ps2_data_oe !== prev_oe && s2 && ps2_clk_oe !== 1'b1) viol++;
    if ((tx_done === 1'b1 || tx_error === 1'b1) && busy !== 1'b0) busy_bad++;
    if (prev_busy && busy === 1'b0 && tx_done !== 1'b1 && tx_error !== 1'b1 && reset !== 1'b1) busy_bad++;
    prev_oe   = ps2_data_oe;
    prev_err  = tx_error;
    prev_busy = busy;
  end

  // One complete host transfer against the device model. abort_at>0 resets after that fall.
  task automatic run_xfer(input logic [7:0] d, input bit nack, input bit extra, input int abort_at,
                          output logic [9:0] bits, output int d_done, output int d_err, output int d_inh);
    int b_done, b_err, b_inh, k;
    b_done = cnt_done;
    b_err  = cnt_err;
    b_inh  = cnt_clkoe;
    bits   = '0;
    check("idle_before_start", busy, 0);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    check("busy_after_accept", busy, 1);
    k = 0;
    while (!(clk_line && !data_line && busy) && k < INH + 50) begin
      @(negedge clock);
      k++;
    end
    check("req_reached", int'(k < INH + 50), 1);
    repeat (4) @(negedge clock);
    for (int f = 1; f <= 11; f++) begin
      if (f == 11) dev_data = nack;
      if (extra && f == 3) begin
        check("busy_at_extra_start", busy, 1);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
      end
      repeat ($urandom_range(6, 10)) @(negedge clock);
      dev_clk = 1'b0;
      repeat ($urandom_range(6, 10)) @(negedge clock);
      if (f <= 10) bits[f-1] = data_line;
      if (f == abort_at) begin
        reset = 1'b1;
        @(negedge clock);
        check("abort_clk_oe", ps2_clk_oe, 0);
        check("abort_data_oe", ps2_data_oe, 0);
        check("abort_busy", busy, 0);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        break;
      end
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
    k = 0;
    while (busy && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("back_to_idle", busy, 0);
    repeat (10) @(negedge clock);
    check("stays_idle", busy, 0);
    d_done = cnt_done - b_done;
    d_err  = cnt_err - b_err;
    d_inh  = cnt_clkoe - b_inh;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         nack;
    bit         extra;
    logic [9:0] exp_bits;
    int         exp_done;
    int         exp_err;
  } vec_t;

  initial begin
    vec_t       vecs[5];
    logic [9:0] bits, exp_bits;
    logic [7:0] d;
    bit         nack;
    int         d_done, d_err, d_inh, k, b_err, b_done;

    // {stop, parity, data[7:0]}: bit k is the line value after fall k+1
    vecs[0] = '{8'hED, 1'b0, 1'b0, 10'h3ED, 1, 0};
    vecs[1] = '{8'h07, 1'b0, 1'b1, 10'h207, 1, 0};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 10'h300, 1, 0};
    vecs[3] = '{8'hA5, 1'b1, 1'b0, 10'h3A5, 0, 1};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 10'h33C, 1, 0};

    reset    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_error", tx_error, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_xfer(vecs[i].data, vecs[i].nack, vecs[i].extra, 0, bits, d_done, d_err, d_inh);
      check($sformatf("vec%0d_bits", i), bits, vecs[i].exp_bits);
      check($sformatf("vec%0d_done", i), d_done, vecs[i].exp_done);
      check($sformatf("vec%0d_err", i), d_err, vecs[i].exp_err);
      check($sformatf("vec%0d_inhibit", i), d_inh, INH);
    end

    for (int i = 0; i < 6; i++) begin
      d    = 8'($urandom_range(0, 255));
      nack = ($urandom_range(0, 3) == 0);
      exp_bits = {1'b1, 1'b0, d};
      if ($countones(d) % 2 == 0) exp_bits[8] = 1'b1;
      run_xfer(d, nack, 1'b0, 0, bits, d_done, d_err, d_inh);
      check($sformatf("rnd%0d_bits", i), bits, exp_bits);
      check($sformatf("rnd%0d_done", i), d_done, nack ? 0 : 1);
      check($sformatf("rnd%0d_err", i), d_err, nack ? 1 : 0);
      check($sformatf("rnd%0d_inhibit", i), d_inh, INH);
    end
    mon_en = 1'b0;

    // Device never clocks: error exactly TO cycles after REQ entry.
    b_err    = cnt_err;
    b_done   = cnt_done;
    tx_data  = 8'h55;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    k = 0;
    while (ps2_clk_oe && k < INH + 10) begin
      @(negedge clock);
      k++;
    end
    check("req_entry_clk_oe", ps2_clk_oe, 0);
    check("req_entry_data_oe", ps2_data_oe, 1);
    k = 0;
    while (tx_error !== 1'b1 && k < TO + 100) begin
      @(negedge clock);
      k++;
    end
    check("timeout_cycles", k, TO);
    check("timeout_busy", busy, 0);
    check("timeout_data_oe", ps2_data_oe, 0);
    repeat (5) @(negedge clock);
    check("timeout_err_pulses", cnt_err - b_err, 1);
    check("timeout_no_done", cnt_done - b_done, 0);

    // Reset after the 5th fall: no pulses, then a clean 0xF4 transfer.
    b_err  = cnt_err;
    b_done = cnt_done;
    run_xfer(8'h96, 1'b0, 1'b0, 5, bits, d_done, d_err, d_inh);
    check("abort_no_done", cnt_done - b_done, 0);
    check("abort_no_err", cnt_err - b_err, 0);
    mon_en = 1'b1;
    run_xfer(8'hF4, 1'b0, 1'b0, 0, bits, d_done, d_err, d_inh);
    check("f4_bits", bits, 10'h2F4);
    check("f4_done", d_done, 1);
    check("f4_err", d_err, 0);
    mon_en = 1'b0;

    check("done_and_error_together", cnt_both, 0);
    check("data_change_clk_high", viol, 0);
    check("oe_after_error", oe_after_err, 0);
    check("busy_timing", busy_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYCLES, default 1000, giving the clock-low inhibit time in clock cycles (100 us at 10 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 150000, giving the maximum transfer time in cycles from clock release to acknowledge (15 ms at 10 MHz).
REQ-003 Port clock, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port tx_data, input, 8 bits: the command byte to send; it SHALL be sampled on the cycle tx_start is accepted.
REQ-006 Port tx_start, input, 1 bit: single-cycle request to send tx_data.
REQ-007 Port ps2_clk_in, input, 1 bit: the raw PS/2 clock line (asynchronous).
REQ-008 Port ps2_data_in, input, 1 bit: the raw PS/2 data line (asynchronous).
REQ-009 Port ps2_clk_oe, output, 1 bit: when 1, the pad SHALL drive the clock line low; when 0, the line is released (open-drain).
REQ-010 Port ps2_data_oe, output, 1 bit: when 1, the pad SHALL drive the data line low; when 0, the line is released.
REQ-011 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 Port tx_done, output, 1 bit: one-cycle pulse on successful, acknowledged completion.
REQ-013 Port tx_error, output, 1 bit: one-cycle pulse on NACK or timeout.

Function
REQ-014 ps2_clk_in and ps2_data_in SHALL each pass through a 2-flop synchronizer; a clock falling edge (fall) SHALL be defined as synchronized previous value 1 and current value 0 (one-cycle pulse).
REQ-015 States SHALL be IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
REQ-016 IDLE: when tx_start=1, the block SHALL latch tx_data, compute parity = ~^tx_data (odd parity), and go to INHIBIT; tx_start in any other state SHALL be ignored.
REQ-017 INHIBIT: ps2_clk_oe=1 and ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles; on the last cycle, ps2_data_oe SHALL be set to 1 (start bit), then the block goes to REQ.
REQ-018 REQ: ps2_clk_oe=0 and ps2_data_oe=1; the timeout counter SHALL clear on entry; on the first fall, the block presents bit 0 and goes to SHIFT with the bit index at 1.
REQ-019 SHIFT: on each fall, the block SHALL present the next bit in order: data bits 1..7 (LSB first), then parity, then stop.
REQ-020 Presenting a bit SHALL mean ps2_data_oe = ~bit, updated in the cycle after fall is detected; the stop bit SHALL be presented as ps2_data_oe=0.
REQ-021 The fall on which the stop bit is presented (the 10th fall counting from REQ) SHALL move the block to ACK.
REQ-022 ACK: on the next fall (the 11th), the block SHALL sample synchronized data; 0 means ACK and the block goes to WAIT_IDLE; 1 means NACK, and tx_error pulses and the block goes to IDLE.
REQ-023 WAIT_IDLE: when synchronized clock=1 and data=1, tx_done SHALL pulse for one cycle and the block goes to IDLE.
REQ-024 The timeout counter SHALL increment every cycle in REQ, SHIFT, ACK and WAIT_IDLE.
REQ-025 When the timeout counter reaches TIMEOUT_CYCLES, both oe outputs SHALL go to 0, tx_error SHALL pulse, and the block goes to IDLE; if timeout and ACK sampling coincide, timeout wins.
REQ-026 Outside the defined driving windows, both oe outputs SHALL be 0; ps2_clk_oe SHALL be 1 only in INHIBIT.
REQ-027 tx_done and tx_error SHALL never be high in the same cycle.
REQ-028 busy SHALL rise the cycle after tx_start is accepted and fall in the same cycle that the tx_done or tx_error pulse is high.

Reset
REQ-029 When reset=1, the block SHALL on that clock edge go to IDLE, set ps2_clk_oe, ps2_data_oe, busy, tx_done and tx_error to 0, clear the bit index and all counters, and set the synchronizers to 1.
REQ-030 Reset asserted mid-transfer SHALL release both lines within one cycle and produce neither a tx_done nor a tx_error pulse.

Verification
REQ-031 tx_data=0xED, the device model clocks and ACKs -> ps2_clk_oe high for exactly INHIBIT_CYCLES cycles; the bits observed on data after falls 1..10 are 1,0,1,1,0,1,1,1, parity 1, stop 1; one tx_done pulse; tx_error stays 0.
REQ-032 tx_data=0x07 and then 0x00 back-to-back -> parity 0 for 0x07 and parity 1 for 0x00; the second tx_start is issued while busy=1 and is ignored until IDLE.
REQ-033 The device holds data high at the 11th fall (NACK) -> tx_error pulses once, no tx_done, both oe outputs are 0 the next cycle.
REQ-034 TIMEOUT_CYCLES=500 and the device never clocks -> tx_error pulses exactly 500 cycles after REQ entry; busy then 0.
REQ-035 Reset is asserted after the 5th fall -> oe outputs are 0 the next cycle and there are no pulses; a new tx_start with 0xF4 then completes normally with parity 0.
REQ-036 A glitch-free random clock period of 60-100 us with data changes checked only while the clock is low -> the host never changes ps2_data_oe while synchronized clock=1, except at start-bit assertion in INHIBIT.
